// File: rtl/adc_snapshot.sv
// Triggered dual-channel ADC snapshot buffer: arm, trigger (software or ch0 rising level),
// then store DEPTH optionally decimated {ch1, ch0} pairs into a simple dual-port RAM.
module adc_snapshot #(
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 10
) (
    input  logic              sys_clk,
    input  logic              rst,
    input  logic [11:0]       adc_data_ch0,
    input  logic [11:0]       adc_data_ch1,
    input  logic              arm,
    input  logic              sw_trig,
    input  logic              trig_mode,
    input  logic [11:0]       trig_level,
    input  logic [7:0]        decim,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [23:0]       rd_data,
    output logic              busy,
    output logic              done,
    output logic [1:0]        state
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ARMED   = 2'd1;
    localparam logic [1:0] ST_CAPTURE = 2'd2;
    localparam logic [1:0] ST_DONE    = 2'd3;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    logic [11:0]       s0_q, s1_q, s0_p_q;
    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]        dec_cnt_q, dec_cnt_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [23:0]       rd_data_q;
    logic              wr_en_s;
    logic              level_trig_s;
    logic              trig_s;
    logic [23:0]       wr_data_s;

    logic [23:0] mem [DEPTH];

    assign level_trig_s = (s0_p_q < trig_level) && (s0_q >= trig_level);
    assign trig_s       = trig_mode ? level_trig_s : sw_trig;
    assign wr_data_s    = {s1_q, s0_q};

    // Capture sequencing; arm overrides everything, including a same-cycle trigger.
    always_comb begin
        state_d   = state_q;
        wr_addr_d = wr_addr_q;
        dec_cnt_d = dec_cnt_q;
        wr_en_s   = 1'b0;
        if (arm) begin
            state_d   = ST_ARMED;
            wr_addr_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_IDLE;
                end
                ST_ARMED: begin
                    if (trig_s) begin
                        wr_en_s   = 1'b1;
                        state_d   = ST_CAPTURE;
                        dec_cnt_d = decim;
                        wr_addr_d = wr_addr_q + ADDR_W'(1);
                    end else begin
                        state_d = ST_ARMED;
                    end
                end
                ST_CAPTURE: begin
                    if (dec_cnt_q == 8'd0) begin
                        wr_en_s   = 1'b1;
                        dec_cnt_d = decim;
                        wr_addr_d = wr_addr_q + ADDR_W'(1);
                        if (wr_addr_q == LAST_ADDR) begin
                            state_d = ST_DONE;
                        end else begin
                            state_d = ST_CAPTURE;
                        end
                    end else begin
                        dec_cnt_d = dec_cnt_q - 8'd1;
                    end
                end
                ST_DONE: begin
                    state_d = ST_DONE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
        busy_d = (state_d == ST_ARMED) || (state_d == ST_CAPTURE);
        done_d = (state_d == ST_DONE);
    end

    // Input pipeline, control state and status registers.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            s0_q      <= 12'd0;
            s1_q      <= 12'd0;
            s0_p_q    <= 12'd0;
            state_q   <= ST_IDLE;
            wr_addr_q <= '0;
            dec_cnt_q <= 8'd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            s0_q      <= adc_data_ch0;
            s1_q      <= adc_data_ch1;
            s0_p_q    <= s0_q;
            state_q   <= state_d;
            wr_addr_q <= wr_addr_d;
            dec_cnt_q <= dec_cnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    // RAM write port; contents intentionally survive reset and re-arm.
    always_ff @(posedge sys_clk) begin
        if (wr_en_s) begin
            mem[wr_addr_q] <= wr_data_s;
        end
    end

    // Registered RAM read port.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            rd_data_q <= 24'd0;
        end else begin
            rd_data_q <= mem[rd_addr];
        end
    end

    assign rd_data = rd_data_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign state   = state_q;

endmodule

// File: tb/tb_adc_snapshot.sv
// Scoreboard bench for adc_snapshot with DEPTH=16: expected RAM words are queued when
// the trigger is issued and popped during readback.
module tb_adc_snapshot;

    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;

    logic              sys_clk = 1'b0;
    logic              rst     = 1'b1;
    logic [11:0]       adc_data_ch0 = 12'd0;
    logic [11:0]       adc_data_ch1 = 12'hFFF;
    logic              arm = 1'b0;
    logic              sw_trig = 1'b0;
    logic              trig_mode = 1'b0;
    logic [11:0]       trig_level = 12'h800;
    logic [7:0]        decim = 8'd0;
    logic [ADDR_W-1:0] rd_addr = '0;
    logic [23:0]       rd_data;
    logic              busy, done;
    logic [1:0]        state;

    int          checks = 0;
    int          failures = 0;
    logic [11:0] s0_cur = 12'd0;
    logic [23:0] exp_q [$];

    adc_snapshot #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .sys_clk(sys_clk), .rst(rst),
        .adc_data_ch0(adc_data_ch0), .adc_data_ch1(adc_data_ch1),
        .arm(arm), .sw_trig(sw_trig), .trig_mode(trig_mode), .trig_level(trig_level),
        .decim(decim), .rd_addr(rd_addr), .rd_data(rd_data),
        .busy(busy), .done(done), .state(state)
    );

    always #5 sys_clk = ~sys_clk;

    function automatic logic [23:0] pair(input logic [11:0] c0);
        return {12'hFFF - c0, c0};
    endfunction

    // Advance one cycle; s0_cur becomes the value the DUT now holds in s0_q.
    task automatic tick(input logic [11:0] nv);
        @(posedge sys_clk);
        #1;
        s0_cur       = adc_data_ch0;
        adc_data_ch0 = nv;
        adc_data_ch1 = 12'hFFF - nv;
    endtask

    // Set the ramp so the DUT holds s0_q == v right now.
    task automatic ramp_to(input logic [11:0] v);
        tick(v);
        tick(v + 12'd1);
    endtask

    // Issue sw_trig in the current cycle and count cycles until done rises.
    task automatic trig_and_wait(input int limit, output int n);
        sw_trig = 1'b1;
        tick(adc_data_ch0 + 12'd1);
        sw_trig = 1'b0;
        n = 1;
        while (!done && n < limit) begin
            tick(adc_data_ch0 + 12'd1);
            n++;
        end
    endtask

    task automatic pulse_arm();
        arm = 1'b1;
        tick(adc_data_ch0 + 12'd1);
        arm = 1'b0;
    endtask

    task automatic readback(input int count, input string name);
        logic [23:0] exp;
        for (int k = 0; k < count; k++) begin
            rd_addr = ADDR_W'(k);
            tick(adc_data_ch0 + 12'd1);
            exp = exp_q.pop_front();
            checks++;
            if (rd_data !== exp) begin
                failures++;
                $display("FAIL %s addr %0d: got %06h expected %06h", name, k, rd_data, exp);
            end
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 4; i++) begin
            sw_trig = i[0];
            arm     = i[1];
            tick(12'(i * 7 + 3));
        end
        arm = 1'b0; sw_trig = 1'b0;
        checks++;
        if ({state, busy, done, rd_data} !== {2'd0, 1'b0, 1'b0, 24'd0}) begin
            failures++;
            $display("FAIL reset: got state=%0d busy=%0b done=%0b rd=%06h expected 0/0/0/0",
                     state, busy, done, rd_data);
        end
        rst = 1'b0;
        tick(12'd0);
        sw_trig = 1'b1;
        tick(12'd1);
        sw_trig = 1'b0;
        tick(12'd2);
        checks++;
        if (state !== 2'd0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL idle_sw_trig: got state=%0d busy=%0b expected 0/0", state, busy);
        end
    endtask

    task automatic test_sw_capture();
        int n;
        decim = 8'd0;
        trig_mode = 1'b0;
        pulse_arm();
        checks++;
        if (state !== 2'd1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL arm_state: got state=%0d busy=%0b expected 1/1", state, busy);
        end
        ramp_to(12'd100);
        for (int k = 0; k < DEPTH; k++) exp_q.push_back(pair(12'(100 + k)));
        trig_and_wait(40, n);
        checks++;
        if (n !== 16 || done !== 1'b1) begin
            failures++;
            $display("FAIL sw_done_latency: got %0d cycles done=%0b expected 16 cycles", n, done);
        end
        readback(DEPTH, "sw_capture");
    endtask

    task automatic test_decim();
        int n;
        decim = 8'd3;
        pulse_arm();
        ramp_to(12'd40);
        for (int k = 0; k < DEPTH; k++) exp_q.push_back(pair(12'(40 + 4 * k)));
        trig_and_wait(100, n);
        checks++;
        if (n !== 61 || done !== 1'b1) begin
            failures++;
            $display("FAIL decim_done_latency: got %0d cycles done=%0b expected 61 cycles", n, done);
        end
        readback(DEPTH, "decim3");
        decim = 8'd0;
    endtask

    task automatic test_level_trigger();
        logic [11:0] seq [7];
        int n;
        seq = '{12'h900, 12'h800, 12'h800, 12'h7F0, 12'h7FE, 12'h801, 12'h802};
        trig_mode  = 1'b1;
        trig_level = 12'h800;
        tick(12'h900);
        tick(12'h900);
        pulse_arm();
        for (int i = 0; i < 7; i++) begin
            tick(seq[i]);
            checks++;
            if (state !== 2'd1) begin
                failures++;
                $display("FAIL level_no_early_trig step %0d: got state=%0d expected 1", i, state);
            end
        end
        tick(12'h803);
        checks++;
        if (state !== 2'd2) begin
            failures++;
            $display("FAIL level_trig: got state=%0d expected 2", state);
        end
        n = 0;
        while (!done && n < 40) begin
            tick(adc_data_ch0 + 12'd1);
            n++;
        end
        checks++;
        if (done !== 1'b1) begin
            failures++;
            $display("FAIL level_done: got done=%0b expected 1", done);
        end
        exp_q.push_back(pair(12'h801));
        exp_q.push_back(pair(12'h802));
        readback(2, "level");
        trig_mode = 1'b0;
    endtask

    task automatic test_rearm();
        int n;
        pulse_arm();
        ramp_to(12'd500);
        sw_trig = 1'b1;
        tick(adc_data_ch0 + 12'd1);
        sw_trig = 1'b0;
        for (int i = 0; i < 4; i++) tick(adc_data_ch0 + 12'd1);
        pulse_arm();
        checks++;
        if (state !== 2'd1 || done !== 1'b0) begin
            failures++;
            $display("FAIL rearm_state: got state=%0d done=%0b expected 1/0", state, done);
        end
        for (int i = 0; i < 3; i++) tick(adc_data_ch0 + 12'd1);
        ramp_to(12'd700);
        for (int k = 0; k < DEPTH; k++) exp_q.push_back(pair(12'(700 + k)));
        trig_and_wait(40, n);
        checks++;
        if (n !== 16 || done !== 1'b1) begin
            failures++;
            $display("FAIL rearm_done_latency: got %0d cycles done=%0b expected 16 cycles", n, done);
        end
        readback(DEPTH, "rearm");
    endtask

    task automatic test_back_to_back();
        int n;
        arm = 1'b1;
        sw_trig = 1'b1;
        tick(adc_data_ch0 + 12'd1);
        arm = 1'b0;
        checks++;
        if (state !== 2'd1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL arm_trig_same: got state=%0d busy=%0b expected 1/1", state, busy);
        end
        exp_q.push_back(pair(s0_cur));
        tick(adc_data_ch0 + 12'd1);
        sw_trig = 1'b0;
        checks++;
        if (state !== 2'd2) begin
            failures++;
            $display("FAIL trig_after_arm: got state=%0d expected 2", state);
        end
        n = 1;
        while (!done && n < 40) begin
            tick(adc_data_ch0 + 12'd1);
            n++;
        end
        checks++;
        if (n !== 16) begin
            failures++;
            $display("FAIL b2b_done_latency: got %0d cycles expected 16", n);
        end
        readback(1, "arm_trig_addr0");
    endtask

    task automatic test_reset_mid_capture();
        logic [23:0] exp;
        pulse_arm();
        ramp_to(12'd900);
        exp = pair(12'd900);
        rd_addr = '0;
        sw_trig = 1'b1;
        tick(adc_data_ch0 + 12'd1);
        sw_trig = 1'b0;
        for (int i = 0; i < 3; i++) tick(adc_data_ch0 + 12'd1);
        rst = 1'b1;
        #1;
        checks++;
        if ({state, busy, done, rd_data} !== {2'd0, 1'b0, 1'b0, 24'd0}) begin
            failures++;
            $display("FAIL async_reset: got state=%0d busy=%0b done=%0b rd=%06h expected 0/0/0/0",
                     state, busy, done, rd_data);
        end
        tick(adc_data_ch0 + 12'd1);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) tick(adc_data_ch0 + 12'd1);
        checks++;
        if (state !== 2'd0) begin
            failures++;
            $display("FAIL reset_stays_idle: got state=%0d expected 0", state);
        end
        exp_q.push_back(exp);
        readback(1, "ram_survives_reset");
    endtask

    initial begin
        test_reset();
        test_sw_capture();
        test_decim();
        test_level_trigger();
        test_rearm();
        test_back_to_back();
        test_reset_mid_capture();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/adc_snapshot.md
# adc_snapshot

Triggered snapshot capture buffer sitting directly downstream of the dual-channel ADC capture stage. It takes the 12-bit per-channel samples produced every `sys_clk` cycle and, after being armed and triggered, stores `DEPTH` optionally decimated sample pairs into on-chip RAM. Software reads the RAM through a random-access read port that the SoC CSR/Wishbone bridge drives. The block gives the SoC an oscilloscope-style view of the ADC signal path without disturbing the ADC-to-DAC loopback.

## Interface
Parameters:
- `DEPTH`, 1024: sample pairs stored per capture; power of two, 16..4096.
- `ADDR_W`, 10: log2(`DEPTH`).

Ports:
- `sys_clk`  in  1  single clock for all logic and RAM.
- `rst`  in  1  asynchronous, active-high reset.
- `adc_data_ch0`  in  12  channel 0 sample, new value every cycle, unsigned.
- `adc_data_ch1`  in  12  channel 1 sample, new value every cycle, unsigned.
- `arm`  in  1  one-cycle pulse: start a new capture (aborts any capture in progress).
- `sw_trig`  in  1  one-cycle pulse: software trigger, honoured only in ARMED.
- `trig_mode`  in  1  0 = software trigger, 1 = ch0 rising level crossing.
- `trig_level`  in  12  level-crossing threshold, unsigned.
- `decim`  in  8  store one sample pair every `decim`+1 cycles.
- `rd_addr`  in  ADDR_W  read address.
- `rd_data`  out  24  {ch1, ch0} at `rd_addr`; ch0 in [11:0].
- `busy`  out  1  high in ARMED or CAPTURE.
- `done`  out  1  high in DONE.
- `state`  out  2  0 IDLE, 1 ARMED, 2 CAPTURE, 3 DONE.

## Operation
- Input stage: `adc_data_ch*` are registered into `s0_q`/`s1_q`. The previous `s0_q` is also held as `s0_p` for edge detection.
- Level trigger: fires when `s0_p < trig_level` and `s0_q >= trig_level`. The compare is a 12-bit unsigned compare.
- Trigger condition `trig`: `sw_trig` when `trig_mode`=0; level trigger when `trig_mode`=1.
- `trig_mode`, `trig_level` and `decim` are sampled continuously. Software keeps them static while `busy`=1.
- IDLE: waits for `arm`. `arm` moves to ARMED.
- ARMED: `trig` moves to CAPTURE. The `{s1_q, s0_q}` present in that same cycle is written to address 0.
- Decimation:
  - When the trigger fires, the decimation counter loads `decim`.
  - While in CAPTURE, the counter decrements each cycle.
  - When it reaches 0, the current `{s1_q, s0_q}` is written to the next address and the counter reloads `decim`.
- Write address increments after each write. The write to address `DEPTH`-1 moves to DONE on the next edge. There is no wrap.
- DONE: holds until `arm` arrives, then moves to ARMED.
- `arm` in any state moves to ARMED next cycle, resets the write address to 0 and discards the partial capture.
- `arm` and `trig` in the same cycle: `arm` wins, and no write happens that cycle. A trigger is accepted from the following cycle onward.
- `sw_trig` outside ARMED, and level crossings outside ARMED, are ignored.
- RAM:
  - Simple dual-port: one write port from the capture logic, one synchronous read port.
  - Contents are not cleared by `rst` or `arm`.
  - Reads during CAPTURE return whatever is stored; there is no collision guard.

## Timing
- Reset values:
  - `state`=IDLE, `busy`=0, `done`=0, `rd_data`=0.
  - Write address 0, decimation counter 0, `s0_q`/`s1_q`/`s0_p`=0.
- ADC input to `s*_q`: 1 cycle. A sample on the pins at edge N is the candidate for storage at edge N+1.
- Read latency: `rd_data` reflects `rd_addr` one cycle after `rd_addr` is presented (registered RAM output).
- Write cadence: writes occur on the trigger cycle T, then at T+k·(`decim`+1), for k = 1..`DEPTH`-1.
- Last write occurs at cycle T+(`DEPTH`-1)(`decim`+1). `done` goes to 1 on the following cycle.
- `decim`=0 stores every cycle. `decim`=255 stores every 256 cycles.
- `busy`/`done`/`state` are registered; they change one cycle after the causing event.
- `rst` asserted mid-capture:
  - All outputs go to reset values immediately (asynchronous).
  - Capture resumes only after a new `arm`.
  - RAM keeps its partial data.

## Test plan
- Reset with inputs toggling: `state`=0, `busy`=0, `done`=0, `rd_data`=0. Pulsing `sw_trig` from IDLE causes no state change.
- Software capture, ch0 = ramp 0,1,2,…, ch1 = 0xFFF − ch0, `decim`=0, `DEPTH`=16:
  - Pulse `arm`, then pulse `sw_trig` at ramp value 100.
  - Readback must give addr k = {0xFFF−(100+k), 100+k}.
  - `done` rises exactly 16 cycles after the trigger cycle.
- `decim`=3, same ramp, trigger at value 40: addr k holds ch0 = 40+4k. `done` rises 61 cycles after the trigger.
- Level trigger, `trig_level`=0x800, ch0 = sine crossing 0x7FE→0x801:
  - Address 0 holds ch0 = 0x801.
  - A prior falling crossing and a value held at 0x800 do not trigger.
- Re-arm mid capture:
  - `arm` after 5 writes.
  - The next trigger restarts at address 0, and `done` rises only after a full 16 further writes.
- `arm` and `sw_trig` in the same cycle:
  - No capture starts; `state`=1.
  - A `sw_trig` one cycle later starts the capture, storing that cycle's sample at address 0.
